// File: rtl/vga_pkg.sv
// Shared raster timing constants for the 640x480@60 Hz display path.
// The game-state and colour-decision blocks import this package for the
// screen geometry so all three agree on width, height and coordinate size.
package vga_pkg;

  localparam int COORD_W = 10;

  // Default timing: 25 MHz pixel rate derived from the 50 MHz board clock.
  localparam int   CLK_DIV_DEF  = 2;
  localparam int   H_ACTIVE_DEF = 640;
  localparam int   H_FP_DEF     = 16;
  localparam int   H_SYNC_DEF   = 96;
  localparam int   H_BP_DEF     = 48;
  localparam int   V_ACTIVE_DEF = 480;
  localparam int   V_FP_DEF     = 10;
  localparam int   V_SYNC_DEF   = 2;
  localparam int   V_BP_DEF     = 33;
  localparam logic SYNC_POL_DEF = 1'b0;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Region of a counter along one axis of the raster.
  localparam logic [1:0] REG_ACTIVE      = 2'd0;
  localparam logic [1:0] REG_FRONT_PORCH = 2'd1;
  localparam logic [1:0] REG_SYNC        = 2'd2;
  localparam logic [1:0] REG_BACK_PORCH  = 2'd3;

  // Classify a counter value into its region given the segment lengths.
  function automatic logic [1:0] axis_region(input logic [COORD_W-1:0] c,
                                             input int act_len,
                                             input int fp_len,
                                             input int sync_len);
    int ci;
    ci = int'(c);
    if (ci < act_len)                          return REG_ACTIVE;
    else if (ci < act_len + fp_len)            return REG_FRONT_PORCH;
    else if (ci < act_len + fp_len + sync_len) return REG_SYNC;
    else                                       return REG_BACK_PORCH;
  endfunction

endpackage

// File: rtl/pixel_ce_div.sv
// Clock-enable divider: produces a registered one-clk pulse every DIV clocks.
// With DIV=1 the pulse is held high while enabled. DIV is legal in 1..4.
module pixel_ce_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic en,
  output logic pix_ce
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1; pulse for the clk after the count reached its last value.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt    <= '0;
      pix_ce <= 1'b0;
    end else if (!en) begin
      cnt    <= '0;
      pix_ce <= 1'b0;
    end else begin
      pix_ce <= (cnt == LAST);
      cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus a registered decode
// of sync, active-video and line/frame strobes. Outputs lag the counters by
// one pixel because they are loaded from the pre-increment counter values.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = CLK_DIV_DEF,
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               en,
  output logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic               active,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] HC_LAST  = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] VC_LAST  = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] VC_BLANK = COORD_W'(V_ACTIVE);
  localparam logic               SYNC_IDLE = ~SYNC_POL;

  logic [COORD_W-1:0] hc;
  logic [COORD_W-1:0] vc;
  logic [1:0]         h_region;
  logic [1:0]         v_region;

  pixel_ce_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .resetb (resetb),
    .en     (en),
    .pix_ce (pix_ce)
  );

  // Region decode of the current (pre-increment) counters.
  always_comb begin
    h_region = axis_region(hc, H_ACTIVE, H_FP, H_SYNC);
    v_region = axis_region(vc, V_ACTIVE, V_FP, V_SYNC);
  end

  // Raster counters: step one pixel per pix_ce, line advances on the hc wrap.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hc <= '0;
      vc <= '0;
    end else if (!en) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_ce) begin
      if (hc == HC_LAST) begin
        hc <= '0;
        vc <= (vc == VC_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Output register: loads on pix_ce, strobes fall back to zero the next clk.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      px         <= '0;
      py         <= '0;
      active     <= 1'b0;
      hsync      <= SYNC_IDLE;
      vsync      <= SYNC_IDLE;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else if (!en) begin
      px         <= '0;
      py         <= '0;
      active     <= 1'b0;
      hsync      <= SYNC_IDLE;
      vsync      <= SYNC_IDLE;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      if (pix_ce) begin
        px         <= hc;
        py         <= vc;
        active     <= (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
        hsync      <= (h_region == REG_SYNC) ? SYNC_POL : SYNC_IDLE;
        vsync      <= (v_region == REG_SYNC) ? SYNC_POL : SYNC_IDLE;
        line_tick  <= (hc == '0);
        frame_tick <= (hc == '0) && (vc == VC_BLANK);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Three instances share clk/resetb/en:
//   0: default 640x480 timing, CLK_DIV=2, active-low sync
//   1: reduced raster 31x19, CLK_DIV=3, active-low sync
//   2: reduced raster 33x15, CLK_DIV=1, active-high sync
// A closed-form reference model derives every output from the number of
// enabled clocks since the last restart.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pix_ce;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       line_tick;
    logic       frame_tick;
    logic [9:0] px;
    logic [9:0] py;
  } vga_out_t;

  localparam logic [2:0] POL = 3'b100;

  logic       clk;
  logic       resetb;
  logic       en;
  logic [2:0] pce, hs, vs, act, lt, ft;
  logic [9:0] px_s [3];
  logic [9:0] py_s [3];

  vga_out_t obs_o [3];
  vga_out_t exp_o [3];

  int n;
  int errors;
  int checks;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  vga_timing_gen u_def (
    .clk(clk), .resetb(resetb), .en(en), .pix_ce(pce[0]), .hsync(hs[0]),
    .vsync(vs[0]), .active(act[0]), .px(px_s[0]), .py(py_s[0]),
    .line_tick(lt[0]), .frame_tick(ft[0])
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(5),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .resetb(resetb), .en(en), .pix_ce(pce[1]), .hsync(hs[1]),
    .vsync(vs[1]), .active(act[1]), .px(px_s[1]), .py(py_s[1]),
    .line_tick(lt[1]), .frame_tick(ft[1])
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(6),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_fast (
    .clk(clk), .resetb(resetb), .en(en), .pix_ce(pce[2]), .hsync(hs[2]),
    .vsync(vs[2]), .active(act[2]), .px(px_s[2]), .py(py_s[2]),
    .line_tick(lt[2]), .frame_tick(ft[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs_o[g] = {pce[g], hs[g], vs[g], act[g], lt[g], ft[g], px_s[g], py_s[g]};
  end

  // ---------------- reference model ----------------
  // Enabled-clock counter since the last reset release / re-enable.
  always @(posedge clk or negedge resetb) begin
    if (!resetb)  n <= 0;
    else if (!en) n <= 0;
    else          n <= n + 1;
  end

  function automatic vga_out_t reset_out(input logic pol);
    vga_out_t o;
    o = '0;
    o.hsync = ~pol;
    o.vsync = ~pol;
    return o;
  endfunction

  // After n enabled clocks: pix_ce is high when n is a positive multiple of d;
  // pixel k is presented from clock d*(k+1)+1 onward.
  function automatic vga_out_t model(input int cnt, input int d,
                                     input int ha, input int hfp, input int hsw, input int hb,
                                     input int va, input int vfp, input int vsw, input int vb,
                                     input logic pol);
    vga_out_t o;
    int ht, vt, p, x, y;
    logic load;
    ht = ha + hfp + hsw + hb;
    vt = va + vfp + vsw + vb;
    o = reset_out(pol);
    o.pix_ce = (cnt > 0) && (cnt % d == 0);
    if (cnt - 1 >= d) begin
      p    = (cnt - 1) / d - 1;
      x    = p % ht;
      y    = (p / ht) % vt;
      load = ((cnt - 1) % d == 0);
      o.px = 10'(x);
      o.py = 10'(y);
      o.active = (x < ha) && (y < va);
      o.hsync  = (x >= ha + hfp && x < ha + hfp + hsw) ? pol : ~pol;
      o.vsync  = (y >= va + vfp && y < va + vfp + vsw) ? pol : ~pol;
      o.line_tick  = load && (x == 0);
      o.frame_tick = load && (x == 0) && (y == va);
    end
    return o;
  endfunction

  always_comb begin
    exp_o[0] = model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, POL[0]);
    exp_o[1] = model(n, 3, 16, 4, 6, 5, 10, 2, 3, 4, POL[1]);
    exp_o[2] = model(n, 1, 20, 3, 4, 6, 8, 2, 2, 3, POL[2]);
  end

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_o[i] !== reset_out(POL[i])) begin
        errors++;
        $display("FAIL reset_idle inst=%0d got=%h exp=%h", i, obs_o[i], reset_out(POL[i]));
      end
    end
    en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_o[i] !== reset_out(POL[i])) begin
        errors++;
        $display("FAIL reset_en_held inst=%0d got=%h exp=%h", i, obs_o[i], reset_out(POL[i]));
      end
    end
  endtask

  task automatic test_line;
    int cyc = 0, first_pce = -1, last_lt = -1, fall = -1;
    int lt_seen = 0, fall_seen = 0, rise_seen = 0;
    logic prev_hs = 1'b1;
    resetb = 1'b1;
    repeat (1600 * 3 + 20) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_o[i] !== exp_o[i]) begin
          errors++;
          $display("FAIL line_model inst=%0d n=%0d got=%h exp=%h", i, n, obs_o[i], exp_o[i]);
        end
      end
      if (pce[0] && first_pce < 0) first_pce = cyc;
      if (lt[0]) begin
        if (last_lt >= 0) begin
          checks++;
          if (cyc - last_lt !== 1600) begin
            errors++;
            $display("FAIL line_tick_period got=%0d exp=1600", cyc - last_lt);
          end
        end
        last_lt = cyc;
        lt_seen++;
      end
      if (!hs[0] && prev_hs) begin
        fall = cyc;
        fall_seen++;
        checks++;
        if (cyc - last_lt !== 1312) begin
          errors++;
          $display("FAIL hsync_fall_offset got=%0d exp=1312", cyc - last_lt);
        end
      end
      if (hs[0] && !prev_hs) begin
        rise_seen++;
        checks++;
        if (cyc - fall !== 192) begin
          errors++;
          $display("FAIL hsync_width got=%0d exp=192", cyc - fall);
        end
      end
      prev_hs = hs[0];
    end
    checks++;
    if (first_pce !== 2) begin
      errors++;
      $display("FAIL first_pix_ce got=%0d exp=2", first_pce);
    end
    checks++;
    if (lt_seen < 3 || fall_seen < 3 || rise_seen < 3) begin
      errors++;
      $display("FAIL line_events got lt=%0d fall=%0d rise=%0d exp>=3 each", lt_seen, fall_seen, rise_seen);
    end
  endtask

  task automatic test_frame;
    int cyc = 0, last_ft1 = -1, last_ft2 = -1, win = -1, act_cnt = 0;
    int ft1_seen = 0, ft2_seen = 0, vs_fall = -1, vs_seen = 0, viol = 0;
    logic prev_vs = vs[1];
    repeat (2 * 1767 + 10) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_o[i] !== exp_o[i]) begin
          errors++;
          $display("FAIL frame_model inst=%0d n=%0d got=%h exp=%h", i, n, obs_o[i], exp_o[i]);
        end
      end
      if (act[1] && (px_s[1] >= 10'd16 || py_s[1] >= 10'd10)) viol++;
      if (win >= 0 && cyc < win + 1767 && pce[1] && act[1]) act_cnt++;
      if (ft[1]) begin
        ft1_seen++;
        if (win < 0) win = cyc;
        checks++;
        if (py_s[1] !== 10'd10 || px_s[1] !== 10'd0) begin
          errors++;
          $display("FAIL frame_tick_pos got px=%0d py=%0d exp px=0 py=10", px_s[1], py_s[1]);
        end
        if (last_ft1 >= 0) begin
          checks++;
          if (cyc - last_ft1 !== 1767) begin
            errors++;
            $display("FAIL frame_period_small got=%0d exp=1767", cyc - last_ft1);
          end
        end
        last_ft1 = cyc;
      end
      if (ft[2]) begin
        ft2_seen++;
        if (last_ft2 >= 0) begin
          checks++;
          if (cyc - last_ft2 !== 495) begin
            errors++;
            $display("FAIL frame_period_fast got=%0d exp=495", cyc - last_ft2);
          end
        end
        last_ft2 = cyc;
      end
      if (!vs[1] && prev_vs && last_ft1 >= 0) begin
        vs_fall = cyc;
        checks++;
        if (cyc - last_ft1 !== 186) begin
          errors++;
          $display("FAIL vsync_fall_offset got=%0d exp=186", cyc - last_ft1);
        end
      end
      if (vs[1] && !prev_vs && vs_fall >= 0) begin
        vs_seen++;
        checks++;
        if (cyc - vs_fall !== 279) begin
          errors++;
          $display("FAIL vsync_width got=%0d exp=279", cyc - vs_fall);
        end
      end
      prev_vs = vs[1];
    end
    checks++;
    if (act_cnt !== 160) begin
      errors++;
      $display("FAIL active_count got=%0d exp=160", act_cnt);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL active_outside got=%0d exp=0", viol);
    end
    checks++;
    if (ft1_seen < 2 || ft2_seen < 2 || vs_seen < 1) begin
      errors++;
      $display("FAIL frame_events got ft1=%0d ft2=%0d vs=%0d", ft1_seen, ft2_seen, vs_seen);
    end
  endtask

  task automatic test_async_reset;
    logic found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_o[i] !== exp_o[i]) begin
          errors++;
          $display("FAIL arst_pre_model inst=%0d n=%0d got=%h exp=%h", i, n, obs_o[i], exp_o[i]);
        end
      end
      if (vs[1] == 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL arst_wait_vsync timeout got=no_vsync exp=vsync_low");
    end
    repeat ($urandom_range(0, 100)) @(negedge clk);
    #($urandom_range(1, 3));
    resetb = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_o[i] !== reset_out(POL[i])) begin
        errors++;
        $display("FAIL arst_immediate inst=%0d got=%h exp=%h", i, obs_o[i], reset_out(POL[i]));
      end
    end
    repeat ($urandom_range(1, 4)) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_o[i] !== reset_out(POL[i])) begin
          errors++;
          $display("FAIL arst_hold inst=%0d got=%h exp=%h", i, obs_o[i], reset_out(POL[i]));
        end
      end
    end
    resetb = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_o[i] !== exp_o[i]) begin
          errors++;
          $display("FAIL arst_restart_model inst=%0d n=%0d got=%h exp=%h", i, n, obs_o[i], exp_o[i]);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (px_s[0] !== 10'd0 || py_s[0] !== 10'd0 || act[0] !== 1'b1 || lt[0] !== 1'b1) begin
          errors++;
          $display("FAIL arst_first_pixel got px=%0d py=%0d act=%b lt=%b exp 0 0 1 1",
                   px_s[0], py_s[0], act[0], lt[0]);
        end
      end
    end
  endtask

  task automatic test_en_gap;
    int first_lt0 = -1, first_lt1 = -1, first_ft1 = -1;
    repeat ($urandom_range(100, 1500)) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_o[i] !== exp_o[i]) begin
          errors++;
          $display("FAIL engap_pre_model inst=%0d n=%0d got=%h exp=%h", i, n, obs_o[i], exp_o[i]);
        end
      end
    end
    en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_o[i] !== reset_out(POL[i])) begin
          errors++;
          $display("FAIL engap_cleared inst=%0d got=%h exp=%h", i, obs_o[i], reset_out(POL[i]));
        end
      end
    end
    en = 1'b1;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_o[i] !== exp_o[i]) begin
          errors++;
          $display("FAIL engap_restart_model inst=%0d n=%0d got=%h exp=%h", i, n, obs_o[i], exp_o[i]);
        end
      end
      if (lt[0] && first_lt0 < 0) first_lt0 = cyc;
      if (lt[1] && first_lt1 < 0) first_lt1 = cyc;
      if (ft[1] && first_ft1 < 0) first_ft1 = cyc;
    end
    checks++;
    if (first_lt0 !== 3) begin
      errors++;
      $display("FAIL engap_first_line got=%0d exp=3", first_lt0);
    end
    checks++;
    if (first_lt1 < 0 || first_ft1 - first_lt1 !== 930) begin
      errors++;
      $display("FAIL engap_frame_delay got=%0d exp=930", first_ft1 - first_lt1);
    end
  endtask

  task automatic test_random_en;
    for (int seg = 0; seg < 20; seg++) begin
      en = 1'b1;
      repeat ($urandom_range(1, 300)) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (obs_o[i] !== exp_o[i]) begin
            errors++;
            $display("FAIL rand_en_model inst=%0d n=%0d got=%h exp=%h", i, n, obs_o[i], exp_o[i]);
          end
        end
      end
      en = 1'b0;
      repeat ($urandom_range(1, 12)) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (obs_o[i] !== exp_o[i]) begin
            errors++;
            $display("FAIL rand_en_off_model inst=%0d n=%0d got=%h exp=%h", i, n, obs_o[i], exp_o[i]);
          end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    resetb = 1'b0;
    en     = 1'b0;
    errors = 0;
    checks = 0;
    test_reset;
    test_line;
    test_frame;
    test_async_reset;
    test_en_gap;
    test_random_en;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the 50 MHz board clock. Outputs: hsync/vsync, an active-video flag and the current pixel coordinate. Sits directly downstream of the game-state logic (ball/paddle positions) and upstream of the pixel colour decision, which compares px/py against object geometry. frame_tick is the once-per-frame strobe the game logic uses to advance ball position during vertical blanking.

Parameters:
CLK_DIV, 2, clk cycles per pixel (50 MHz / 2 = 25 MHz pixel rate); legal 1..4
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clk  in  1  system clock, 50 MHz
resetb  in  1  asynchronous active-low reset
en  in  1  timing enable; low holds raster at origin
pix_ce  out  1  one-clk pulse per pixel period
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
active  out  1  high while (px,py) is in the visible area
px  out  10  pixel column, 0..H_TOTAL-1
py  out  10  line number, 0..V_TOTAL-1
line_tick  out  1  one-clk pulse at start of each line
frame_tick  out  1  one-clk pulse at start of vertical blanking

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (resetb low, asynchronous): divider, hc and vc = 0. pix_ce, active, line_tick and frame_tick = 0. px = py = 0. hsync and vsync = !SYNC_POL (inactive).
- Divider: counts 0..CLK_DIV-1 while en=1. pix_ce is registered and high for the one clk in which the divider equals CLK_DIV-1. With CLK_DIV=1, pix_ce is constantly high while en=1.
- Raster counters advance only on pix_ce cycles:
  - hc wraps H_TOTAL-1 -> 0.
  - vc increments on the hc wrap, and wraps V_TOTAL-1 -> 0 on the same edge as the hc wrap.
- Output register loads on each pix_ce edge, from the pre-increment (hc,vc). Latency is one pixel:
  - px = hc, py = vc
  - active = (hc < H_ACTIVE) && (vc < V_ACTIVE)
  - hsync = SYNC_POL while H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else !SYNC_POL
  - vsync = SYNC_POL while V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, else !SYNC_POL
  - line_tick = (hc == 0)
  - frame_tick = (hc == 0 && vc == V_ACTIVE)
- line_tick and frame_tick are cleared on the next clk. Each is exactly one clk wide regardless of CLK_DIV.
- The first pix_ce edge after reset release with en=1 presents px=0, py=0, active=1, line_tick=1.
- en deasserted: on the next clk, the divider, hc and vc clear to 0 and all outputs take their reset values. On re-enable, behaviour is identical to a fresh reset release.
- Reset asserted mid-frame: all state clears immediately. No partial sync pulse is extended.
- Counters are 10 bits. No arithmetic overflow is possible within legal parameters.
- There is no internal FSM beyond the counters. The raster region is decoded as ACTIVE, FRONT_PORCH, SYNC or BACK_PORCH on each axis.

Decomposition:
- Shared package vga_pkg holds the timing constants (the defaults above, H_TOTAL, V_TOTAL) and coordinate width (10). The game-state and colour-decision blocks use the same package for screen width/height.
- One natural sub-module: pixel_ce_div (parameterised clk-enable divider producing pix_ce). The raster counters and decode stay in vga_timing_gen.

Test Plan:
- Reset release, en=1, default params -> first pix_ce at clk 2; pix_ce period 2 clks; px sequence 0,1,...,799,0; line_tick period 1600 clks.
- hsync measurement -> low for exactly 192 clks (96 pixels), falling 1312 clks (656 pixels) after line_tick; high elsewhere.
- Full frame -> vsync low exactly 2 lines (3200 clks) starting at py=490; frame_tick period 840000 clks, asserted when py=480, px=0.
- Count active=1 on pix_ce cycles over one frame -> 307200; active never high with px>=640 or py>=480.
- Async reset pulse at py=200, px=300 -> outputs immediately at reset values (hsync=vsync=1, px=py=0). Restart yields px=0, py=0 at first pix_ce.
- en low for 10 clks mid-line, then high -> outputs cleared on the clk after en falls. Raster restarts at (0,0), and the next frame_tick comes 768000 clks after the first pix_ce.
